// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state encoding and legal width bounds for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sa_state_e;

    localparam int SA_W_MIN = 2;
    localparam int SA_W_MAX = 32;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle; ovf exists only with SERIAL_ADDER_OVF_EN
interface serial_adder_if #(
    parameter int W = 8
);
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;

    modport master (output start, sub, a, b, c_in, input busy, done, sum, c_out, ovf);
    modport slave  (input start, sub, a, b, c_in, output busy, done, sum, c_out, ovf);
`else
    modport master (output start, sub, a, b, c_in, input busy, done, sum, c_out);
    modport slave  (input start, sub, a, b, c_in, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational 1-bit full adder shared by every bit position
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial add/sub, one bit per clock; SERIAL_ADDER_OVF_EN adds ovf
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(W);

    if (W < SA_W_MIN || W > SA_W_MAX) begin : g_w_check
        $error("serial_adder: W outside supported range");
    end

    sa_state_e     state_q, state_d;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic [CW-1:0] cnt_q;
    logic          carry_q, c_out_q, busy_q, done_q;
    logic          fa_s, fa_co;
    logic          last, load;

    assign last = (cnt_q == CW'(W - 1));

    serial_fa_cell u_cell (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                load    = 1'b1;
            end
            RUN:  if (last) state_d = DONE;
            DONE: begin
                state_d = bus.start ? RUN : IDLE;
                load    = bus.start;
            end
            default: state_d = IDLE;
        endcase
    end

    // The result register doubles as the sum shift register; it settles at the last RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
            if (load) begin
                a_q     <= bus.a;
                b_q     <= bus.sub ? ~bus.b : bus.b;
                carry_q <= bus.sub | bus.c_in;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> 1;
                b_q     <= b_q >> 1;
                sum_q   <= {fa_s, sum_q[W-1:1]};
                carry_q <= fa_co;
                cnt_q   <= cnt_q + 1'b1;
                if (last) c_out_q <= fa_co;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the MSB cycle carry_q is the carry into the sign bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           ovf_q <= 1'b0;
        else if (state_q == RUN && last)      ovf_q <= carry_q ^ fa_co;
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed checks of serial_adder at W = 8, 2, 5, 32
module tb_serial_adder;

    localparam int NI = 4;

    function automatic int wsel(input int k);
        case (k)
            0:       return 8;
            1:       return 2;
            2:       return 5;
            default: return 32;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n_r [NI];
    logic        start_r [NI];
    logic        sub_r   [NI];
    logic        cin_r   [NI];
    logic [31:0] a_r     [NI];
    logic [31:0] b_r     [NI];
    logic        busy_w  [NI];
    logic        done_w  [NI];
    logic [31:0] sum_w   [NI];
    logic        c_w     [NI];
    logic        ovf_w   [NI];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g
        localparam int W = wsel(gi);

        serial_adder_if #(.W(W)) bus ();
        logic rstn;

        assign rstn        = rst_n_r[gi];
        assign bus.start   = start_r[gi];
        assign bus.sub     = sub_r[gi];
        assign bus.c_in    = cin_r[gi];
        assign bus.a       = a_r[gi][W-1:0];
        assign bus.b       = b_r[gi][W-1:0];
        assign busy_w[gi]  = bus.busy;
        assign done_w[gi]  = bus.done;
        assign sum_w[gi]   = 32'(bus.sum);
        assign c_w[gi]     = bus.c_out;
`ifdef SERIAL_ADDER_OVF_EN
        assign ovf_w[gi]   = bus.ovf;
`else
        assign ovf_w[gi]   = 1'b0;
`endif

        serial_adder #(.W(W)) dut (
            .clk   (clk),
            .rst_n (rstn),
            .bus   (bus)
        );

        // Reference: an accepted operation completes W edges later with plain integer arithmetic.
        bit           act = 0, e_busy = 0, e_done = 0, e_c = 0, e_v = 0, p_c = 0, p_v = 0;
        int           left = 0;
        logic [W-1:0] e_sum = '0, p_sum = '0;

        initial forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                act = 0; left = 0; e_busy = 0; e_done = 0;
                e_sum = '0; e_c = 0; e_v = 0;
            end else begin
                bit     was_run;
                longint mask, half, ua, ub, ci, full, sa, sb, ssum;
                was_run = act;
                e_done  = 0;
                if (act) begin
                    left--;
                    if (left == 0) begin
                        act = 0; e_done = 1;
                        e_sum = p_sum; e_c = p_c; e_v = p_v;
                    end
                end
                if (!was_run && start_r[gi]) begin
                    mask  = (longint'(1) << W) - 1;
                    half  = longint'(1) << (W - 1);
                    ua    = longint'(a_r[gi][W-1:0]);
                    ub    = longint'(b_r[gi][W-1:0]);
                    if (sub_r[gi]) ub = mask - ub;
                    ci    = (sub_r[gi] || cin_r[gi]) ? 1 : 0;
                    full  = ua + ub + ci;
                    p_sum = W'(full);
                    p_c   = ((full >> W) & 1) != 0;
                    sa    = (ua >= half) ? ua - (mask + 1) : ua;
                    sb    = (ub >= half) ? ub - (mask + 1) : ub;
                    ssum  = sa + sb + ci;
                    p_v   = (ssum >= half) || (ssum < -half);
                    act   = 1;
                    left  = W;
                end
                e_busy = act;
            end
        end

        initial begin
            @(posedge clk);
            forever begin
                @(negedge clk);
                chk($sformatf("w%0d busy", W), 64'(busy_w[gi]), 64'(e_busy));
                chk($sformatf("w%0d done", W), 64'(done_w[gi]), 64'(e_done));
                if (!e_busy) begin
                    chk($sformatf("w%0d sum", W), 64'(sum_w[gi]), 64'(e_sum));
                    chk($sformatf("w%0d c_out", W), 64'(c_w[gi]), 64'(e_c));
`ifdef SERIAL_ADDER_OVF_EN
                    chk($sformatf("w%0d ovf", W), 64'(ovf_w[gi]), 64'(e_v));
`endif
                end
            end
        end
    end

    task automatic launch(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb);
        a_r[i] = a; b_r[i] = b; cin_r[i] = ci; sub_r[i] = sb; start_r[i] = 1'b1;
    endtask

    // Call just after the accept edge (plus off further edges); latency counts edges from acceptance.
    task automatic wait_done(input int i, input int off, input string name,
                             output logic [31:0] s, output logic c, output logic v);
        int lat;
        bit seen;
        seen = 0;
        for (lat = off; lat < wsel(i) + 4; lat++) begin
            @(negedge clk);
            if (done_w[i]) begin
                seen = 1;
                break;
            end
        end
        chk({name, " latency"}, seen ? 64'(lat) : 64'hFFFF, 64'(wsel(i)));
        s = sum_w[i]; c = c_w[i]; v = ovf_w[i];
    endtask

    task automatic run_op(input int i, input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb,
                          output logic [31:0] s, output logic c, output logic v);
        @(posedge clk); #1;
        launch(i, a, b, ci, sb);
        @(posedge clk); #1;
        start_r[i] = 1'b0;
        wait_done(i, 0, name, s, c, v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        logic        c, v;
        int          dn;

        for (int k = 0; k < NI; k++) begin
            rst_n_r[k] = 1'b0; start_r[k] = 1'b0; sub_r[k] = 1'b0;
            cin_r[k] = 1'b0; a_r[k] = '0; b_r[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy_w[0]), 64'd0);
        chk("reset done", 64'(done_w[0]), 64'd0);
        chk("reset sum",  64'(sum_w[0]),  64'd0);
        chk("reset c_out", 64'(c_w[0]),   64'd0);
        for (int k = 0; k < NI; k++) rst_n_r[k] = 1'b1;

        run_op(0, "add 35+4a", 32'h35, 32'h4A, 1'b0, 1'b0, s, c, v);
        chk("add 35+4a sum", 64'(s), 64'h7F);
        chk("add 35+4a c_out", 64'(c), 64'd0);
        run_op(0, "add ff+01+1", 32'hFF, 32'h01, 1'b1, 1'b0, s, c, v);
        chk("add ff+01+1 sum", 64'(s), 64'h01);
        chk("add ff+01+1 c_out", 64'(c), 64'd1);
`ifdef SERIAL_ADDER_OVF_EN
        run_op(0, "add 7f+01", 32'h7F, 32'h01, 1'b0, 1'b0, s, c, v);
        chk("add 7f+01 sum", 64'(s), 64'h80);
        chk("add 7f+01 ovf", 64'(v), 64'd1);
`endif
        run_op(0, "sub 10-20", 32'h10, 32'h20, 1'b1, 1'b1, s, c, v);
        chk("sub 10-20 sum", 64'(s), 64'hF0);
        chk("sub 10-20 c_out", 64'(c), 64'd0);
        run_op(0, "sub 20-10", 32'h20, 32'h10, 1'b0, 1'b1, s, c, v);
        chk("sub 20-10 sum", 64'(s), 64'h10);
        chk("sub 20-10 c_out", 64'(c), 64'd1);

        // A start pulse in the middle of RUN must not disturb the operation in flight.
        @(posedge clk); #1;
        launch(0, 32'h11, 32'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        launch(0, 32'hAA, 32'hBB, 1'b1, 1'b1);
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        wait_done(0, 3, "ignore", s, c, v);
        chk("ignore sum", 64'(s), 64'h33);
        chk("ignore c_out", 64'(c), 64'd0);

        // Back-to-back: start presented while done is high.
        run_op(0, "b2b first", 32'h35, 32'h4A, 1'b0, 1'b0, s, c, v);
        chk("b2b first sum", 64'(s), 64'h7F);
        launch(0, 32'h90, 32'h0F, 1'b0, 1'b1);
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        wait_done(0, 0, "b2b second", s, c, v);
        chk("b2b second sum", 64'(s), 64'h81);
        chk("b2b second c_out", 64'(c), 64'd1);

        // Reset during RUN cycle 4 clears everything at once and suppresses done.
        @(posedge clk); #1;
        launch(0, 32'h55, 32'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_r[0] = 1'b0;
        #1;
        chk("abort busy", 64'(busy_w[0]), 64'd0);
        chk("abort done", 64'(done_w[0]), 64'd0);
        chk("abort sum", 64'(sum_w[0]), 64'd0);
        chk("abort c_out", 64'(c_w[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n_r[0] = 1'b1;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_w[0]) dn++;
        end
        chk("abort no done", 64'(dn), 64'd0);
        run_op(0, "after abort", 32'h12, 32'h34, 1'b0, 1'b0, s, c, v);
        chk("after abort sum", 64'(s), 64'h46);

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int m = 0; m < 3; m++)
                    run_op(1, "w2 exhaustive", 32'(a), 32'(b), m == 1, m == 2, s, c, v);

        for (int idx = 0; idx < NI; idx++) begin
            if (idx == 1) continue;
            repeat (200)
                run_op(idx, $sformatf("w%0d random", wsel(idx)), $urandom, $urandom,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, c, v);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
